// File: rtl/dtw_core_ctrl_if.sv
// Query-stream, query-buffer, reference-fetch and PE-result signals of the DTW core controller.
// Latency: none, this is a wiring bundle only.
// Backpressure: the stream side uses tvalid/tready; the other groups are fire-and-forget strobes.
// master modport = controller side, slave modport = stream source / buffer / PE array side.
interface dtw_core_ctrl_if #(
  parameter int QUERY_LEN  = 250,
  parameter int REF_ADDR_W = 16
);
  localparam int QW = $clog2(QUERY_LEN);

  // AXI-Stream query input
  logic [15:0]           s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tlast;
  logic                  s_axis_tready;
  // query buffer write port
  logic                  q_wr_en;
  logic [QW-1:0]         q_wr_addr;
  logic [15:0]           q_wr_data;
  // PE array control and reference fetch
  logic                  pe_clear;
  logic                  ref_rd_en;
  logic [REF_ADDR_W-1:0] ref_rd_addr;
  // PE array result
  logic [31:0]           pe_score;
  logic                  pe_score_valid;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output q_wr_en, q_wr_addr, q_wr_data,
    output pe_clear, ref_rd_en, ref_rd_addr,
    input  pe_score, pe_score_valid
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  q_wr_en, q_wr_addr, q_wr_data,
    input  pe_clear, ref_rd_en, ref_rd_addr,
    output pe_score, pe_score_valid
  );
endinterface

// File: rtl/dtw_core_ctrl.sv
// Sequencer between the DTW register block and the PE array: load query, clear PEs, sweep reference, capture score.
// Latency: LOAD one cycle after the start edge; buffer writes one cycle after each handshake; DONE one cycle after pe_score_valid.
// Backpressure: s_axis_tready is high for the whole of LOAD; the PE side has no backpressure and is bounded by TIMEOUT.
// Ports: S_AXI_ACLK/S_AXI_ARESETN clock and sync active-low reset; dtw_cr/dtw_ref_len control inputs;
//        dtw_sr/dtw_score/irq status outputs; bus = stream, query-buffer, reference-fetch and PE-result group.
module dtw_core_ctrl #(
  parameter int QUERY_LEN  = 250,
  parameter int REF_ADDR_W = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic [31:0] dtw_cr,
  input  logic [31:0] dtw_ref_len,
  output logic [31:0] dtw_sr,
  output logic [31:0] dtw_score,
  output logic        irq,
  dtw_core_ctrl_if.master bus
);

  localparam int QW = $clog2(QUERY_LEN);
  localparam int DW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LW = REF_ADDR_W + 1;
  // Largest legal reference length, widened so a 32-bit request compares without truncation.
  localparam logic [32:0] MAX_LEN = 33'd1 << REF_ADDR_W;
  localparam logic [QW-1:0] LAST_SAMPLE = QW'(QUERY_LEN - 1);
  localparam logic [DW-1:0] LAST_DRAIN  = DW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  state_t        state_q, state_n;
  logic [1:0]    prev_cr_q;          // {bit3, bit0} of dtw_cr from the previous cycle
  logic [LW-1:0] ref_len_q, ref_len_n;
  logic [LW-1:0] idx_q, idx_n;
  logic [QW-1:0] cnt_q, cnt_n;
  logic [DW-1:0] drain_q, drain_n;
  logic          done_q, done_n;
  logic          err_q, err_n;
  logic          irq_q, irq_n;
  logic [31:0]   score_q, score_n;
  logic          wr_en_q, wr_en_n;
  logic [QW-1:0] wr_addr_q, wr_addr_n;
  logic [15:0]   wr_data_q, wr_data_n;

  logic start_edge, clr_edge, soft_rst, len_bad, last_sample, busy;

  // Only bits [3:0] of the control word carry meaning.
  logic unused_cr_bits;
  assign unused_cr_bits = ^dtw_cr[31:4];

  assign start_edge  = dtw_cr[0] & ~prev_cr_q[0];
  assign clr_edge    = dtw_cr[3] & ~prev_cr_q[1];
  assign soft_rst    = dtw_cr[1];
  assign len_bad     = (dtw_ref_len == 32'd0) || ({1'b0, dtw_ref_len} > MAX_LEN);
  assign last_sample = (cnt_q == LAST_SAMPLE);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= ST_IDLE;
      prev_cr_q <= 2'b00;
      ref_len_q <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      drain_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
      score_q   <= 32'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 16'd0;
    end else begin
      state_q   <= state_n;
      prev_cr_q <= {dtw_cr[3], dtw_cr[0]};
      ref_len_q <= ref_len_n;
      idx_q     <= idx_n;
      cnt_q     <= cnt_n;
      drain_q   <= drain_n;
      done_q    <= done_n;
      err_q     <= err_n;
      irq_q     <= irq_n;
      score_q   <= score_n;
      wr_en_q   <= wr_en_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n   = state_q;
    ref_len_n = ref_len_q;
    idx_n     = idx_q;
    cnt_n     = cnt_q;
    drain_n   = drain_q;
    done_n    = done_q;
    err_n     = err_q;
    score_n   = score_q;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr_q;
    wr_data_n = wr_data_q;

    if (soft_rst) begin
      // Overrides every other event, including a start edge in the same cycle.
      state_n = ST_IDLE;
      done_n  = 1'b0;
      err_n   = 1'b0;
      score_n = 32'd0;
    end else begin
      if (clr_edge) begin
        done_n = 1'b0;
        err_n  = 1'b0;
        if (state_q == ST_DONE || state_q == ST_ERR) begin
          state_n = ST_IDLE;
        end
      end

      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          // A start edge here takes precedence over the clear edge's move to IDLE.
          if (start_edge) begin
            if (len_bad) begin
              state_n = ST_ERR;
              err_n   = 1'b1;
            end else begin
              state_n   = ST_LOAD;
              ref_len_n = dtw_ref_len[LW-1:0];
              done_n    = 1'b0;
              err_n     = 1'b0;
              cnt_n     = '0;
            end
          end
        end

        ST_LOAD: begin
          if (bus.s_axis_tvalid) begin
            wr_en_n   = 1'b1;
            wr_addr_n = cnt_q;
            wr_data_n = bus.s_axis_tdata;
            // Hold at the last index rather than wrapping; the FSM leaves LOAD on that sample anyway.
            if (!last_sample) begin
              cnt_n = cnt_q + 1'b1;
            end
            if (bus.s_axis_tlast && last_sample) begin
              state_n = ST_CLEAR;
            end else if (bus.s_axis_tlast || last_sample) begin
              state_n = ST_ERR;
              err_n   = 1'b1;
            end
          end
        end

        ST_CLEAR: begin
          idx_n   = '0;
          state_n = ST_RUN;
        end

        ST_RUN: begin
          idx_n = idx_q + 1'b1;
          if (idx_q == ref_len_q - 1'b1) begin
            state_n = ST_DRAIN;
            drain_n = '0;
          end
        end

        ST_DRAIN: begin
          // A score arriving on the timeout cycle is still accepted.
          if (bus.pe_score_valid) begin
            score_n = bus.pe_score;
            done_n  = 1'b1;
            state_n = ST_DONE;
          end else if (drain_q == LAST_DRAIN) begin
            err_n   = 1'b1;
            state_n = ST_ERR;
          end else begin
            drain_n = drain_q + 1'b1;
          end
        end

        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end

    // Registered so that done/error and irq become visible in the same cycle.
    irq_n = (done_n | err_n) & dtw_cr[2];
  end

  // ---------------------------------------------------------------------------
  // Outputs, all decoded from registers
  // ---------------------------------------------------------------------------
  assign busy = (state_q == ST_LOAD) || (state_q == ST_CLEAR) ||
                (state_q == ST_RUN)  || (state_q == ST_DRAIN);

  assign dtw_sr    = {25'd0, state_q, irq_q, err_q, done_q, busy};
  assign dtw_score = score_q;
  assign irq       = irq_q;

  assign bus.s_axis_tready = (state_q == ST_LOAD);
  assign bus.q_wr_en       = wr_en_q;
  assign bus.q_wr_addr     = wr_addr_q;
  assign bus.q_wr_data     = wr_data_q;
  assign bus.pe_clear      = (state_q == ST_CLEAR);
  assign bus.ref_rd_en     = (state_q == ST_RUN);
  assign bus.ref_rd_addr   = idx_q[REF_ADDR_W-1:0];

endmodule

// File: doc/dtw_core_ctrl.md
# dtw_core_ctrl

Sequencing controller between the DTW AXI-Lite register block and the DTW processing-element (PE) array. It consumes the control word and the reference length, and loads one query of QUERY_LEN samples from an AXI-Stream into the query buffer. It then sweeps reference addresses 0..ref_len-1 into the PE array and captures the final score. It produces the status word read back over AXI-Lite, plus a level interrupt.

## Interface
- QUERY_LEN, 250, query samples per run (≥2)
- REF_ADDR_W, 16, reference address width; maximum ref_len = 2^REF_ADDR_W
- TIMEOUT, 1024, maximum DRAIN cycles waiting for pe_score_valid
- S_AXI_ACLK  in  1  single clock, rising edge
- S_AXI_ARESETN  in  1  reset, synchronous, active-low
- dtw_cr  in  32  control word: [0] start (rising edge), [1] soft reset (level), [2] irq enable, [3] clear done/error (rising edge)
- dtw_ref_len  in  32  reference length, sampled on start
- dtw_sr  out  32  status: [0] busy, [1] done, [2] error, [3] irq, [6:4] state code, [31:7] 0
- dtw_score  out  32  captured score
- irq  out  1  level interrupt
- s_axis_tdata  in  16  query sample
- s_axis_tvalid  in  1  sample valid
- s_axis_tlast  in  1  last sample of query
- s_axis_tready  out  1  sample accepted
- q_wr_en / q_wr_addr / q_wr_data  out  1 / clog2(QUERY_LEN) / 16  query buffer write port
- pe_clear  out  1  one-cycle PE array clear
- ref_rd_en / ref_rd_addr  out  1 / REF_ADDR_W  reference fetch
- pe_score / pe_score_valid  in  32 / 1  final PE result

## Operation
- State codes: IDLE=0, LOAD=1, CLEAR=2, RUN=3, DRAIN=4, DONE=5, ERR=6.
- A start edge is dtw_cr[0] & ~prev_cr[0]; prev_cr resets to 0. The bit 3 clear edge is detected the same way.
- **IDLE / DONE / ERR, start edge:**
  - If dtw_ref_len==0 or dtw_ref_len > 2^REF_ADDR_W: go to ERR and set error.
  - Otherwise latch ref_len, clear done, error and the sample count, and go to LOAD.
- **Busy states:** busy = LOAD|CLEAR|RUN|DRAIN. A start edge while busy is ignored, and so is a change to dtw_ref_len.
- **LOAD:**
  - s_axis_tready=1. Each handshake writes q_wr_addr=count, q_wr_data=tdata, then increments count.
  - tlast must coincide exactly with sample QUERY_LEN-1. That handshake goes to CLEAR.
  - An early tlast, or a missing tlast on the final sample, goes to ERR. The offending sample is still written.
- **CLEAR:** pe_clear=1 for one cycle, ref index=0, then RUN.
- **RUN:** ref_rd_en=1, ref_rd_addr=index, and the index increments every cycle. After the cycle with index==ref_len-1, go to DRAIN. RUN therefore lasts exactly ref_len cycles.
- **DRAIN:**
  - Counts cycles from 0.
  - When pe_score_valid is sampled: dtw_score←pe_score, done←1, go to DONE.
  - If the count reaches TIMEOUT-1 without pe_score_valid: error←1, go to ERR.
  - If pe_score_valid and the timeout coincide, the score wins.
- pe_score_valid outside DRAIN is ignored.
- **Clear edge (dtw_cr[3]):** clears done and error. The state is unchanged, except that DONE/ERR go to IDLE.
- **Soft reset (dtw_cr[1]=1):** every state goes to IDLE on the next edge, with done, error and dtw_score cleared. While the bit is held, start edges are ignored. Soft reset has priority over all other events.
- **irq:** irq = (done|error) & dtw_cr[2]. dtw_sr[3] mirrors irq.

## Timing
- Hardware reset: state IDLE; all outputs 0; dtw_sr=0; dtw_score=0.
- s_axis_tready, ref_rd_en, ref_rd_addr, pe_clear and dtw_sr[6:0] are decoded from registers only. There is no combinational path from any input to any output.
- q_wr_en/addr/data are registered and appear one cycle after the handshake.
- Start edge sampled at edge T: LOAD from T+1.
- With tvalid held high: CLEAR at T+1+QUERY_LEN, RUN starts one cycle later, and DRAIN starts ref_len cycles after that.
- done/DONE are visible the cycle after pe_score_valid is sampled.
- Counter widths: the sample count needs clog2(QUERY_LEN) bits. The ref index and latched ref_len need REF_ADDR_W+1 bits, so the maximum length compares without wrap. No counter wraps silently.

## Test plan
- **Nominal run:** QUERY_LEN=4, ref_len=8, dtw_cr=0x5 edge, 4 samples with tlast on the 4th, pe_score_valid with pe_score=0x1234 on the 3rd DRAIN cycle. Required response:
  - q_wr_addr 0..3
  - one pe_clear pulse
  - ref_rd_addr 0..7 on 8 consecutive cycles
  - dtw_score=0x1234, dtw_sr=0x5A, irq=1
- **Bad ref_len:** dtw_ref_len=0 with start edge → dtw_sr=0x64, no tready, no pe_clear. Clear edge → dtw_sr=0x00.
- **Early tlast:** QUERY_LEN=4, tlast on sample 2 → ERR (dtw_sr=0x64), no pe_clear, no ref_rd_en.
- **Timeout:** TIMEOUT=16 and no pe_score_valid → ERR exactly 16 cycles after DRAIN entry; dtw_score stays 0.
- **Soft reset mid-RUN:** assert dtw_cr[1] at index 3 → next cycle ref_rd_en=0, dtw_sr=0. A start edge while the bit is held is ignored.
- **Busy robustness:** tvalid with random gaps, a second start edge during RUN, and dtw_ref_len changed mid-run → the sequence is unchanged, with exactly QUERY_LEN writes and the originally latched ref_len fetches.
